// File: rtl/instr_mem_pkg.sv
// Shared widths, FSM state type and parity helper for the instruction memory.
package instr_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Even parity: the stored bit makes the total count of ones (byte + bit) even.
  function automatic logic even_parity(input logic [BYTE_W-1:0] i_byte);
    return ^i_byte;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Byte-wide instruction storage: one byte write port and one combinational block read port.
// With INSTR_MEM_PARITY_EN defined, a parity bit is kept per byte and checked on read.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_we,
  input  logic [ADDR_W-1:0]                     i_waddr,
  input  logic [BYTE_W-1:0]                     i_wdata,
  input  logic [ADDR_W-3-$clog2(BLOCK_WORDS):0] i_raddr,
  output logic [WORD_W*BLOCK_WORDS-1:0]         o_rdata
`ifdef INSTR_MEM_PARITY_EN
  ,
  output logic                                  o_par_err
`endif
);

  localparam int OFF_W       = 2 + $clog2(BLOCK_WORDS);
  localparam int BLOCK_BYTES = BLOCK_WORDS * (WORD_W / BYTE_W);

  logic [BYTE_W-1:0] r_mem [2**ADDR_W];
`ifdef INSTR_MEM_PARITY_EN
  logic              r_par [2**ADDR_W];
  logic [BLOCK_BYTES-1:0] w_par_bad;
`endif

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
`ifdef INSTR_MEM_PARITY_EN
      r_par[i_waddr] <= even_parity(i_wdata);
`endif
    end
  end

  // Byte j of the block sits at bits [8j+7:8j], which gives little-endian words.
  for (genvar j = 0; j < BLOCK_BYTES; j++) begin : g_byte
    logic [ADDR_W-1:0] w_idx;
    assign w_idx = {i_raddr, OFF_W'(j)};
    assign o_rdata[j*BYTE_W +: BYTE_W] = r_mem[w_idx];
`ifdef INSTR_MEM_PARITY_EN
    assign w_par_bad[j] = r_par[w_idx] != even_parity(r_mem[w_idx]);
`endif
  end

`ifdef INSTR_MEM_PARITY_EN
  assign o_par_err = |w_par_bad;
`endif

endmodule

// File: rtl/instr_memory.sv
// Block-read instruction memory with fixed READ_LATENCY and a byte program-load port.
// Defining INSTR_MEM_PARITY_EN adds per-byte even parity and the o_parity_err output.
module instr_memory
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int BLOCK_WORDS  = 4,
  parameter int READ_LATENCY = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic                                  i_read,
  input  logic [ADDR_W-3-$clog2(BLOCK_WORDS):0] i_address,
  output logic [WORD_W*BLOCK_WORDS-1:0]         o_readdata,
  output logic                                  o_busywait,
  input  logic                                  i_load_en,
  input  logic [ADDR_W-1:0]                     i_load_addr,
  input  logic [BYTE_W-1:0]                     i_load_data
`ifdef INSTR_MEM_PARITY_EN
  ,
  output logic                                  o_parity_err
`endif
);

  localparam int BLK_AW = ADDR_W - 2 - $clog2(BLOCK_WORDS);
  localparam int CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  state_t                        r_state;
  logic [CNT_W-1:0]              r_count;
  logic [BLK_AW-1:0]             r_addr;
  logic [WORD_W*BLOCK_WORDS-1:0] r_readdata;
  logic [WORD_W*BLOCK_WORDS-1:0] w_rdata;
  logic                          w_accept;
  logic                          w_load_we;
`ifdef INSTR_MEM_PARITY_EN
  logic                          r_parity_err;
  logic                          w_par_err;
`endif

  // Reset low masks both the read request and the load strobe.
  assign w_accept   = i_reset_n && (r_state == IDLE) && i_read;
  assign w_load_we  = i_reset_n && (r_state == IDLE) && !i_read && i_load_en;
  assign o_busywait = (r_state == BUSY) || w_accept;
  assign o_readdata = r_readdata;
`ifdef INSTR_MEM_PARITY_EN
  assign o_parity_err = r_parity_err;
`endif

  instr_mem_array #(
    .ADDR_W      (ADDR_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_load_we),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
`ifdef INSTR_MEM_PARITY_EN
    ,
    .o_par_err (w_par_err)
`endif
  );

  // Accept edge loads READ_LATENCY-1; the edge that sees zero captures the block.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_addr     <= '0;
      r_readdata <= '0;
`ifdef INSTR_MEM_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_read) begin
            r_addr  <= i_address;
            r_count <= CNT_LOAD;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_count == '0) begin
            r_readdata <= w_rdata;
`ifdef INSTR_MEM_PARITY_EN
            r_parity_err <= w_par_err;
`endif
            r_state <= IDLE;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_memory.sv
// Randomized self-checking bench for instr_memory: default configuration plus a
// BLOCK_WORDS=1 / READ_LATENCY=1 instance, both against a byte-array reference model.
module tb_instr_memory;

  logic         clk = 1'b0;
  logic         resetN;
  logic         read, read2;
  logic [5:0]   address;
  logic [7:0]   address2;
  logic [127:0] readData;
  logic [31:0]  readData2;
  logic         busy, busy2;
  logic         loadEn, loadEn2;
  logic [9:0]   loadAddr;
  logic [7:0]   loadData;
`ifdef INSTR_MEM_PARITY_EN
  logic         parityErr, parityErr2;
`endif

  logic [7:0]   model [1024];
  logic [127:0] lastExp, lastExp2;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  instr_memory dut (
    .i_clk       (clk),
    .i_reset_n   (resetN),
    .i_read      (read),
    .i_address   (address),
    .o_readdata  (readData),
    .o_busywait  (busy),
    .i_load_en   (loadEn),
    .i_load_addr (loadAddr),
    .i_load_data (loadData)
`ifdef INSTR_MEM_PARITY_EN
    ,
    .o_parity_err (parityErr)
`endif
  );

  instr_memory #(
    .ADDR_W       (10),
    .BLOCK_WORDS  (1),
    .READ_LATENCY (1)
  ) dut2 (
    .i_clk       (clk),
    .i_reset_n   (resetN),
    .i_read      (read2),
    .i_address   (address2),
    .o_readdata  (readData2),
    .o_busywait  (busy2),
    .i_load_en   (loadEn2),
    .i_load_addr (loadAddr),
    .i_load_data (loadData)
`ifdef INSTR_MEM_PARITY_EN
    ,
    .o_parity_err (parityErr2)
`endif
  );

  // Block contents straight from the byte model: byte j of the block at bits 8j.
  function automatic logic [127:0] expBlock(input int blk, input int words);
    logic [127:0] r;
    int base;
    r = '0;
    base = blk * 4 * words;
    for (int j = 0; j < 4 * words; j++) r[8*j +: 8] = model[(base + j) % 1024];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One legal program-load byte written into both instances.
  task automatic applyStimulus(input int addr, input logic [7:0] data);
    @(negedge clk);
    loadEn = 1'b1; loadEn2 = 1'b1;
    loadAddr = addr[9:0]; loadData = data;
    model[addr % 1024] = data;
    @(negedge clk);
    loadEn = 1'b0; loadEn2 = 1'b0;
  endtask

  // Issue one read, scramble READ/ADDRESS while busy, then check latency and data.
  task automatic doRead(input bit useSmall, input int blk);
    int cycles;
    int lat;
    logic [127:0] exp;
    lat = useSmall ? 2 : 5;
    exp = expBlock(blk, useSmall ? 1 : 4);
    @(negedge clk);
    if (useSmall) begin read2 = 1'b1; address2 = blk[7:0]; end
    else begin read = 1'b1; address = blk[5:0]; end
    #1;
    cycles = 0;
    while ((useSmall ? busy2 : busy) && cycles < 40) begin
      if (useSmall) checkOutput("holdData2", {96'b0, readData2}, lastExp2);
      else checkOutput("holdData", readData, lastExp);
      @(negedge clk);
      read = 1'b0; read2 = 1'b0;
      address = 6'($urandom); address2 = 8'($urandom);
      #1;
      cycles++;
    end
    checkOutput(useSmall ? "latency2" : "latency", 128'(cycles), 128'(lat));
    if (useSmall) begin
      checkOutput("readData2", {96'b0, readData2}, exp);
      lastExp2 = exp;
    end else begin
      checkOutput("readData", readData, exp);
      lastExp = exp;
    end
  endtask

  initial begin
    int spins;
    resetN = 1'b0; read = 1'b1; read2 = 1'b1; address = '0; address2 = '0;
    loadEn = 1'b1; loadEn2 = 1'b1; loadAddr = '0; loadData = 8'h55;
    lastExp = '0; lastExp2 = '0;

    // Reset with READ and LOAD_EN asserted: both must be ignored.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstBusy", 128'(busy), 128'(0));
    checkOutput("rstBusy2", 128'(busy2), 128'(0));
    checkOutput("rstData", readData, '0);
    checkOutput("rstData2", {96'b0, readData2}, '0);
`ifdef INSTR_MEM_PARITY_EN
    checkOutput("rstPar", 128'(parityErr), 128'(0));
`endif
    @(negedge clk);
    resetN = 1'b1; read = 1'b0; read2 = 1'b0; loadEn = 1'b0; loadEn2 = 1'b0;

    for (int i = 0; i < 1024; i++) applyStimulus(i, (i < 16) ? 8'(i) : 8'($urandom));

    // Block 0 of the counting pattern.
    doRead(1'b0, 0);
    checkOutput("word0", 128'(readData[31:0]), 128'(32'h03020100));
    checkOutput("word3", 128'(readData[127:96]), 128'(32'h0F0E0D0C));

    // READ held high: block 1 then block 2 with no idle cycle between them.
    @(negedge clk); read = 1'b1; address = 6'd1; #1;
    checkOutput("b2bBusy", 128'(busy), 128'(1));
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); address = 6'd2; #1;
      checkOutput("b2bBusyA", 128'(busy), 128'(1));
      checkOutput("b2bHold", readData, lastExp);
    end
    @(negedge clk); #1;
    checkOutput("b2bBlock1", readData, expBlock(1, 4));
    checkOutput("b2bNoGap", 128'(busy), 128'(1));
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk); #1;
      checkOutput("b2bBusyB", 128'(busy), 128'(1));
      checkOutput("b2bHold1", readData, expBlock(1, 4));
    end
    @(negedge clk); read = 1'b0; #1;
    checkOutput("b2bBlock2", readData, expBlock(2, 4));
    checkOutput("b2bIdle", 128'(busy), 128'(0));

    // Reset on the second BUSY cycle aborts the read.
    @(negedge clk); read = 1'b1; address = 6'd3;
    @(negedge clk); read = 1'b0;
    @(negedge clk); resetN = 1'b0;
    @(negedge clk); resetN = 1'b1; #1;
    checkOutput("abortBusy", 128'(busy), 128'(0));
    checkOutput("abortData", readData, '0);
    lastExp = '0; lastExp2 = '0;
    doRead(1'b0, 3);

    // Load strobes while a read is requested or in flight are dropped.
    @(negedge clk); read = 1'b1; address = 6'd5;
    loadEn = 1'b1; loadAddr = 10'd0; loadData = 8'hAA;
    @(negedge clk); read = 1'b0;
    @(negedge clk); loadEn = 1'b0; #1;
    spins = 0;
    while (busy && spins < 40) begin @(negedge clk); #1; spins++; end
    checkOutput("dropBlock5", readData, expBlock(5, 4));
    lastExp = expBlock(5, 4);
    doRead(1'b0, 0);
    checkOutput("dropWord0", 128'(readData[31:0]), 128'(32'h03020100));

    // A legal load is visible to the next read.
    applyStimulus(0, 8'hAA);
    doRead(1'b0, 0);
    checkOutput("loadWord0", 128'(readData[31:0]), 128'(32'h030201AA));

    // Small instance: top block address reads bytes 1020..1023.
    doRead(1'b1, 255);
    checkOutput("maxWord", {96'b0, readData2},
                {96'b0, model[1023], model[1022], model[1021], model[1020]});
    doRead(1'b1, 0);

    for (int n = 0; n < 12; n++) begin
      applyStimulus(int'($urandom_range(0, 1023)), 8'($urandom));
      if (n % 2 == 0) doRead(1'b0, int'($urandom_range(0, 63)));
      else doRead(1'b1, int'($urandom_range(0, 255)));
    end

`ifdef INSTR_MEM_PARITY_EN
    doRead(1'b0, 0);
    checkOutput("parClean", 128'(parityErr), 128'(0));
    dut.u_array.r_par[5] = ~dut.u_array.r_par[5];
    doRead(1'b0, 0);
    checkOutput("parBad", 128'(parityErr), 128'(1));
    doRead(1'b0, 1);
    checkOutput("parOther", 128'(parityErr), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
